id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter REGW, default 5, register index width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hold stage contents.
REQ-006 SHALL have port flush  input  1  kill stage contents (branch redirect).
REQ-007 SHALL have port id_valid  input  1  decode slot holds a real instruction.
REQ-008 SHALL have ports id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN each  decoded PC, register-file reads, sign-extended immediate.
REQ-009 SHALL have ports id_rs1, id_rs2, id_rd  input  REGW each  source and destination indices.
REQ-010 SHALL have ports id_field  input  4  ALU select {funct7[5],funct3}; id_alu_src  input  1  op2 = immediate; id_reg_write, id_mem_read  input  1 each.
REQ-011 SHALL have ports exmem_rd, memwb_rd  input  REGW; exmem_reg_write, memwb_reg_write  input  1; exmem_result, memwb_result  input  XLEN  forwarding sources.
REQ-012 SHALL have outputs ex_valid 1, ex_pc XLEN, ex_op1 XLEN, ex_op2 XLEN, ex_store_data XLEN, ex_field 4, ex_rd REGW, ex_reg_write 1, ex_mem_read 1.
REQ-013 SHALL have output load_use_hazard  1  request upstream stall.

Function
REQ-014 On each clk edge with flush=1, ex_valid SHALL become 0 and ex_reg_write, ex_mem_read SHALL become 0; flush SHALL override stall.
REQ-015 With flush=0, stall=0: all id_* values SHALL be captured; ex_valid <= id_valid; ex_reg_write/ex_mem_read captured ANDed with id_valid.
REQ-016 With flush=0, stall=1: contents SHALL hold, except held rs1/rs2 data SHALL be refreshed with memwb_result when memwb_reg_write=1, memwb_rd!=0 and memwb_rd matches the held index.
REQ-017 Forwarded operand A SHALL be: exmem_result if exmem_reg_write and exmem_rd==held rs1 and rs1!=0; else memwb_result if same test on MEM/WB; else held rs1 data (EX/MEM priority).
REQ-018 Forwarded operand B SHALL use the identical rule on held rs2.
REQ-019 ex_op1 SHALL equal forwarded A; ex_op2 SHALL equal held immediate when held alu_src=1, else forwarded B; ex_store_data SHALL always equal forwarded B.
REQ-020 Forwarding SHALL be combinational from held registers and forwarding inputs (zero added latency); pipeline latency id_* to ex_* SHALL be exactly one cycle.
REQ-021 Index 0 SHALL never be forwarded; x0 operand SHALL read held data (0 from register file).
REQ-022 load_use_hazard SHALL be 1 when ex_valid, ex_mem_read, ex_rd!=0, id_valid and (id_rs1==ex_rd or (id_alu_src==0 and id_rs2==ex_rd)); combinational.
REQ-023 ex_field SHALL pass id_field unmodified; no ALU evaluation inside this block.
REQ-024 When ex_valid=0, ex_op1/ex_op2 values SHALL be don't-care but ex_reg_write and ex_mem_read SHALL be 0.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear every register: ex_valid, ex_reg_write, ex_mem_read 0; ex_pc, held data, immediate, indices, ex_field, alu_src 0.
REQ-026 Reset deassertion mid-stream SHALL yield a bubble stage until first capture; rst_n SHALL dominate flush and stall.

Structure
REQ-027 ALU field encodings (ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101, SLT 0010, SLTU 0011), XLEN, REGW SHALL live in shared package cpu_pkg.
REQ-028 One sub-module fwd_mux (held index, held data, EX/MEM and MEM/WB tuples -> operand) SHALL be instantiated twice.

Verification
REQ-029 Reset: rst_n low mid-cycle -> all outputs 0 immediately, ex_valid 0.
REQ-030 EX/MEM forward: held rs1=5, exmem_rd=5, exmem_reg_write=1, exmem_result=0x1234 -> ex_op1=0x1234; also memwb_rd=5 with 0xBEEF -> still 0x1234.
REQ-031 x0 guard: held rs2=0, exmem_rd=0, exmem_result=0xFFFFFFFF, alu_src=0 -> ex_op2=0.
REQ-032 Stall refresh: stall=1 holding rs1=7 (data 0x1), memwb_rd=7, memwb_result=0x55 for one cycle -> after release of MEM/WB, ex_op1=0x55.
REQ-033 Load-use: ex_mem_read=1, ex_rd=3, id_rs2=3, id_alu_src=0, id_valid=1 -> load_use_hazard=1; id_alu_src=1 -> 0.
REQ-034 Flush over stall: flush=1, stall=1 with ex_valid=1 -> next cycle ex_valid=0, ex_reg_write=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath/register-index widths and the
// 4-bit ALU select encodings ({funct7[5], funct3}) carried through ID/EX.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_field_e;

endpackage : cpu_pkg

// File: rtl/fwd_mux.sv
// Operand forwarding selector: picks the newest in-flight value for one held
// source register, EX/MEM before MEM/WB, never forwarding register x0.
module fwd_mux #(
   parameter int XLEN = cpu_pkg::XLEN,
   parameter int REGW = cpu_pkg::REGW
) (
   input  logic [REGW-1:0] rs_idx,
   input  logic [XLEN-1:0] rs_data,
   input  logic [REGW-1:0] exmem_rd,
   input  logic            exmem_reg_write,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [REGW-1:0] memwb_rd,
   input  logic            memwb_reg_write,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] operand
);

   logic exmem_hit;
   logic memwb_hit;

   always_comb begin
      exmem_hit = exmem_reg_write && (rs_idx != '0) && (exmem_rd == rs_idx);
      memwb_hit = memwb_reg_write && (rs_idx != '0) && (memwb_rd == rs_idx);
      operand   = rs_data;
      if (exmem_hit) begin
         operand = exmem_result;
      end else if (memwb_hit) begin
         operand = memwb_result;
      end
   end

endmodule : fwd_mux

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with combinational operand forwarding and
// load-use hazard detection toward the decode stage.
module id_ex_stage #(
   parameter int XLEN = cpu_pkg::XLEN,
   parameter int REGW = cpu_pkg::REGW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic [3:0]      id_field,
   input  logic            id_alu_src,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic [REGW-1:0] exmem_rd,
   input  logic            exmem_reg_write,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [REGW-1:0] memwb_rd,
   input  logic            memwb_reg_write,
   input  logic [XLEN-1:0] memwb_result,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_op1,
   output logic [XLEN-1:0] ex_op2,
   output logic [XLEN-1:0] ex_store_data,
   output logic [3:0]      ex_field,
   output logic [REGW-1:0] ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            load_use_hazard
);

   logic            valid_q,     valid_d;
   logic [XLEN-1:0] pc_q,        pc_d;
   logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
   logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
   logic [XLEN-1:0] imm_q,       imm_d;
   logic [REGW-1:0] rs1_q,       rs1_d;
   logic [REGW-1:0] rs2_q,       rs2_d;
   logic [REGW-1:0] rd_q,        rd_d;
   logic [3:0]      field_q,     field_d;
   logic            alu_src_q,   alu_src_d;
   logic            reg_write_q, reg_write_d;
   logic            mem_read_q,  mem_read_d;

   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;
   logic            wb_hits_rs1;
   logic            wb_hits_rs2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         field_q     <= '0;
         alu_src_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         field_q     <= field_d;
         alu_src_q   <= alu_src_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
      end
   end

   // A write retiring while we are stalled would otherwise be lost to the
   // held instruction, so it is folded into the held register data.
   always_comb begin
      wb_hits_rs1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q);
      wb_hits_rs2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q);
   end

   always_comb begin
      valid_d     = valid_q;
      pc_d        = pc_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      field_d     = field_q;
      alu_src_d   = alu_src_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      if (flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
      end else if (stall) begin
         if (wb_hits_rs1) begin
            rs1_data_d = memwb_result;
         end
         if (wb_hits_rs2) begin
            rs2_data_d = memwb_result;
         end
      end else begin
         valid_d     = id_valid;
         pc_d        = id_pc;
         rs1_data_d  = id_rs1_data;
         rs2_data_d  = id_rs2_data;
         imm_d       = id_imm;
         rs1_d       = id_rs1;
         rs2_d       = id_rs2;
         rd_d        = id_rd;
         field_d     = id_field;
         alu_src_d   = id_alu_src;
         reg_write_d = id_reg_write && id_valid;
         mem_read_d  = id_mem_read && id_valid;
      end
   end

   fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_a (
      .rs_idx          (rs1_q),
      .rs_data         (rs1_data_q),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .exmem_result    (exmem_result),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_result    (memwb_result),
      .operand         (fwd_a)
   );

   fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_b (
      .rs_idx          (rs2_q),
      .rs_data         (rs2_data_q),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .exmem_result    (exmem_result),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_result    (memwb_result),
      .operand         (fwd_b)
   );

   always_comb begin
      ex_valid      = valid_q;
      ex_pc         = pc_q;
      ex_op1        = fwd_a;
      ex_op2        = alu_src_q ? imm_q : fwd_b;
      ex_store_data = fwd_b;
      ex_field      = field_q;
      ex_rd         = rd_q;
      ex_reg_write  = reg_write_q;
      ex_mem_read   = mem_read_q;
   end

   // rs2 only matters to decode when it is not replaced by the immediate.
   always_comb begin
      load_use_hazard = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                        ((id_rs1 == rd_q) || (!id_alu_src && (id_rs2 == rd_q)));
   end

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, checked
// against a per-instruction reference model of the stage.
module tb_id_ex_stage;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            stall = 1'b0;
   logic            flush = 1'b0;
   logic            id_valid = 1'b0;
   logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
   logic [REGW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic [3:0]      id_field = '0;
   logic            id_alu_src = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
   logic [REGW-1:0] exmem_rd = '0, memwb_rd = '0;
   logic            exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
   logic [XLEN-1:0] exmem_result = '0, memwb_result = '0;

   logic            ex_valid;
   logic [XLEN-1:0] ex_pc, ex_op1, ex_op2, ex_store_data;
   logic [3:0]      ex_field;
   logic [REGW-1:0] ex_rd;
   logic            ex_reg_write, ex_mem_read, load_use_hazard;

   int checks = 0;
   int errors = 0;

   // Reference model: the instruction currently occupying EX
   logic            m_valid, m_alu_src, m_rw, m_mr;
   logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
   logic [REGW-1:0] m_rs1, m_rs2, m_rd;
   logic [3:0]      m_field;

   id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_field(id_field),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .exmem_rd(exmem_rd),
      .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
      .memwb_result(memwb_result), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data),
      .ex_field(ex_field), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .load_use_hazard(load_use_hazard)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] ref_fwd(input logic [REGW-1:0] idx,
                                               input logic [XLEN-1:0] held);
      if (idx == 0) return held;
      if (exmem_reg_write && exmem_rd == idx) return exmem_result;
      if (memwb_reg_write && memwb_rd == idx) return memwb_result;
      return held;
   endfunction

   function automatic logic ref_hazard();
      return m_valid && m_mr && (m_rd != 0) && id_valid &&
             ((id_rs1 == m_rd) || (!id_alu_src && id_rs2 == m_rd));
   endfunction

   task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                      input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_alu_src = 0; m_rw = 0; m_mr = 0;
      m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_field = '0;
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
      end else if (flush) begin
         m_valid = 0; m_rw = 0; m_mr = 0;
      end else if (stall) begin
         if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m_rs1) m_rs1d = memwb_result;
         if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m_rs2) m_rs2d = memwb_result;
      end else begin
         m_valid = id_valid; m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
         m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
         m_field = id_field; m_alu_src = id_alu_src;
         m_rw = id_reg_write & id_valid; m_mr = id_mem_read & id_valid;
      end
   endtask

   task automatic check_all();
      chk("ex_valid", XLEN'(ex_valid), XLEN'(m_valid));
      chk("ex_reg_write", XLEN'(ex_reg_write), XLEN'(m_rw));
      chk("ex_mem_read", XLEN'(ex_mem_read), XLEN'(m_mr));
      chk("load_use", XLEN'(load_use_hazard), XLEN'(ref_hazard()));
      if (m_valid) begin
         chk("ex_pc", ex_pc, m_pc);
         chk("ex_op1", ex_op1, ref_fwd(m_rs1, m_rs1d));
         chk("ex_op2", ex_op2, m_alu_src ? m_imm : ref_fwd(m_rs2, m_rs2d));
         chk("ex_store_data", ex_store_data, ref_fwd(m_rs2, m_rs2d));
         chk("ex_field", XLEN'(ex_field), XLEN'(m_field));
         chk("ex_rd", XLEN'(ex_rd), XLEN'(m_rd));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, XLEN'(ex_valid), '0);
      chk({tag, "_rw"}, XLEN'(ex_reg_write), '0);
      chk({tag, "_mr"}, XLEN'(ex_mem_read), '0);
      chk({tag, "_pc"}, ex_pc, '0);
      chk({tag, "_op1"}, ex_op1, '0);
      chk({tag, "_op2"}, ex_op2, '0);
      chk({tag, "_store"}, ex_store_data, '0);
      chk({tag, "_field"}, XLEN'(ex_field), '0);
      chk({tag, "_rd"}, XLEN'(ex_rd), '0);
   endtask

   task automatic set_id(input logic v, input logic [REGW-1:0] rs1,
                         input logic [XLEN-1:0] rs1d, input logic [REGW-1:0] rs2,
                         input logic [XLEN-1:0] rs2d, input logic [REGW-1:0] rd,
                         input logic alu_src, input logic rw, input logic mr);
      id_valid = v; id_rs1 = rs1; id_rs1_data = rs1d; id_rs2 = rs2;
      id_rs2_data = rs2d; id_rd = rd; id_alu_src = alu_src;
      id_reg_write = rw; id_mem_read = mr;
      id_pc = $urandom; id_imm = $urandom; id_field = 4'($urandom_range(0, 15));
   endtask

   task automatic quiet_fwd();
      exmem_reg_write = 0; memwb_reg_write = 0;
      exmem_rd = '0; memwb_rd = '0;
   endtask

   task automatic randomize_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 4) != 0, REGW'($urandom_range(0, 3)), $urandom,
             REGW'($urandom_range(0, 3)), $urandom, REGW'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exmem_rd = REGW'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_result = $urandom;
      memwb_rd = REGW'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_result = $urandom;
   endtask

   initial begin
      model_reset();
      // Reset with busy inputs: outputs must be cleared
      set_id(1, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 0, 1, 1);
      exmem_reg_write = 1; exmem_rd = 5'd1; exmem_result = 32'hDEAD;
      #12;
      check_all_zero("reset");
      @(posedge clk);
      #2 rst_n = 1'b1;
      quiet_fwd();

      // EX/MEM forward takes priority over MEM/WB
      set_id(1, 5'd5, 32'h1, 5'd6, 32'h2, 5'd8, 0, 1, 0);
      step();
      exmem_rd = 5'd5; exmem_reg_write = 1; exmem_result = 32'h1234;
      #1 chk("fwd_exmem", ex_op1, 32'h1234);
      memwb_rd = 5'd5; memwb_reg_write = 1; memwb_result = 32'hBEEF;
      #1 chk("fwd_exmem_prio", ex_op1, 32'h1234);
      exmem_reg_write = 0;
      #1 chk("fwd_memwb", ex_op1, 32'hBEEF);
      quiet_fwd();

      // x0 is never forwarded
      set_id(1, 5'd1, 32'h7, 5'd0, 32'h0, 5'd9, 0, 1, 0);
      step();
      exmem_rd = 5'd0; exmem_reg_write = 1; exmem_result = 32'hFFFF_FFFF;
      memwb_rd = 5'd0; memwb_reg_write = 1; memwb_result = 32'hFFFF_FFFF;
      #1 chk("x0_op2", ex_op2, 32'h0);
      chk("x0_store", ex_store_data, 32'h0);
      quiet_fwd();

      // MEM/WB write during stall refreshes held data
      set_id(1, 5'd7, 32'h1, 5'd2, 32'h3, 5'd4, 0, 1, 0);
      step();
      stall = 1; id_valid = 0;
      memwb_rd = 5'd7; memwb_reg_write = 1; memwb_result = 32'h55;
      step();
      quiet_fwd();
      #1 chk("stall_refresh", ex_op1, 32'h55);
      stall = 0;

      // Load-use hazard detection
      set_id(1, 5'd1, 32'h0, 5'd2, 32'h0, 5'd3, 0, 1, 1);
      step();
      set_id(1, 5'd0, 32'h0, 5'd3, 32'h0, 5'd10, 0, 1, 0);
      #1 chk("load_use_rs2", XLEN'(load_use_hazard), 32'h1);
      id_alu_src = 1;
      #1 chk("load_use_imm", XLEN'(load_use_hazard), 32'h0);

      // Flush beats stall
      set_id(1, 5'd1, 32'h5, 5'd2, 32'h6, 5'd11, 0, 1, 1);
      step();
      chk("pre_flush_valid", XLEN'(ex_valid), 32'h1);
      flush = 1; stall = 1;
      step();
      chk("flush_valid", XLEN'(ex_valid), 32'h0);
      chk("flush_rw", XLEN'(ex_reg_write), 32'h0);
      flush = 0; stall = 0;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         step();
      end

      // Asynchronous reset mid-cycle, then a bubble until first capture
      flush = 0; stall = 0;
      set_id(1, 5'd1, 32'h9, 5'd2, 32'hA, 5'd12, 0, 1, 1);
      step();
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      model_reset();
      step();
      #1 rst_n = 1'b1;
      #1 chk("bubble_valid", XLEN'(ex_valid), 32'h0);
      step();
      for (int i = 0; i < 50; i++) begin
         randomize_inputs();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_id_ex_stage
